branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-stage predictor: a direct-mapped branch target buffer (BTB) with a 2-bit saturating counter per entry.
- Supplies a predicted next-PC to IF for every fetched PC.
- Receives the resolved outcome (pc_src, target) from EX branch resolution.
- Flags mispredictions so the pipeline can flush IF/ID and ID/EX and redirect fetch; keeps branch and mispredict performance counters.

Parameters:
- INDEX_BITS, 4, log2 of BTB entry count (16 entries).
- XLEN, 32, PC/address width.

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- if_pc  input  XLEN  PC currently being fetched
- pred_taken  output  1  IF predicts taken for if_pc
- pred_target  output  XLEN  predicted next PC for if_pc
- ex_valid  input  1  a branch/jump instruction is resolving in EX this cycle
- ex_pc  input  XLEN  PC of the resolving instruction
- ex_taken  input  1  resolved outcome (pc_src from EX)
- ex_uncond  input  1  resolving instruction is jal/jalr
- ex_target  input  XLEN  resolved taken target
- ex_pred_taken  input  1  prediction made for this instruction in IF, piped down
- ex_pred_target  input  XLEN  predicted target, piped down
- bp_flush  input  1  invalidate the whole BTB (fence.i)
- mispredict  output  1  EX outcome differs from prediction
- redirect_pc  output  XLEN  correct next PC when mispredict=1
- branch_count  output  32  resolved branches since reset
- mispredict_count  output  32  mispredictions since reset

Behaviour:
- Indexing: idx = pc[INDEX_BITS+1:2]; tag = pc[XLEN-1:INDEX_BITS+2].
- Each entry holds valid, tag, target, cnt[1:0], uncond.
- Lookup is combinational from registered tables, zero latency:
  - hit = valid[idx] && tag matches.
  - pred_taken = hit && (uncond || cnt[1]).
  - pred_target = pred_taken ? target : if_pc+4. Add is modulo 2^XLEN, so 0xFFFFFFFC wraps to 0.
- Mispredict is combinational and gated by ex_valid:
  - mispredict = ex_valid && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
  - redirect_pc = ex_taken ? ex_target : ex_pc+4.
  - When ex_valid=0: mispredict=0 and redirect_pc=ex_pc+4 (don't-care value, but deterministic).
- Update on rising edge when ex_valid=1, entry addressed by ex_pc:
  - Hit, taken: cnt saturating increment (3 stays 3); target <= ex_target; uncond <= ex_uncond.
  - Hit, not taken: cnt saturating decrement (0 stays 0); target unchanged.
  - Miss, taken: allocate or overwrite: valid=1, tag, target=ex_target, cnt=2'b10, uncond=ex_uncond.
  - Miss, not taken: no change.
- Same-cycle read and write to the same index: lookup returns the pre-update contents. No bypass.
- bp_flush=1: all valid bits cleared at the edge. Counters, tags and targets are untouched. bp_flush has priority over a same-cycle update, i.e. the update is dropped.
- Performance counters:
  - branch_count += 1 when ex_valid.
  - mispredict_count += 1 when mispredict.
  - Both saturate at 0xFFFFFFFF. bp_flush does not clear them.
- Reset (async, rst_n=0):
  - All valid=0, all cnt=2'b01, uncond=0.
  - Both performance counters = 0.
  - Consequently pred_taken=0, pred_target=if_pc+4, mispredict=0 from ex_valid=0.
  - Reset asserted mid-update discards that update.
- No state machine beyond per-entry counters. cnt encoding: 0 = strong NT, 1 = weak NT, 2 = weak T, 3 = strong T.

Test Plan:
- Reset, then if_pc=0x100 → pred_taken=0, pred_target=0x104; both counters 0.
- Resolve beq at ex_pc=0x100, ex_taken=1, ex_target=0x80, ex_pred_taken=0 → mispredict=1, redirect_pc=0x80. Next cycle, if_pc=0x100 gives pred_taken=1, pred_target=0x80. branch_count=1, mispredict_count=1.
- Hysteresis, same PC after allocation (cnt=2):
  - One not-taken resolve → cnt=1, pred_taken=0.
  - Two taken → cnt=3.
  - One not-taken → cnt=2, still predicts taken.
  - Four further taken → cnt stays 3.
- Aliasing: allocate 0x100, then resolve taken at 0x140 (same idx, different tag) → if_pc=0x100 misses (pred_target=0x104); 0x140 hits. Jal at 0x200 with ex_uncond=1 → predicted taken even after not-taken decrements.
- Same cycle: ex update and if_pc lookup both at 0x100 → lookup shows old entry, new entry visible next cycle. Same cycle bp_flush and update → entry invalid afterwards.
- Force mispredict_count to 0xFFFFFFFF, apply another mispredict → count holds at 0xFFFFFFFF. Assert rst_n=0 asynchronously mid-cycle → outputs return to reset values immediately.

Source files
------------

// File: rtl/branch_predictor_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// Purely combinational wiring with no latency of its own.
// No backpressure: lookups and resolves are accepted every cycle.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  // fetch-side lookup
  logic [XLEN-1:0] if_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  // EX-side resolution
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic            ex_taken;
  logic            ex_uncond;
  logic [XLEN-1:0] ex_target;
  logic            ex_pred_taken;
  logic [XLEN-1:0] ex_pred_target;
  logic            bp_flush;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     branch_count;
  logic [31:0]     mispredict_count;

  modport master (
    output if_pc, ex_valid, ex_pc, ex_taken, ex_uncond, ex_target,
           ex_pred_taken, ex_pred_target, bp_flush,
    input  pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );

  modport slave (
    input  if_pc, ex_valid, ex_pc, ex_taken, ex_uncond, ex_target,
           ex_pred_taken, ex_pred_target, bp_flush,
    output pred_taken, pred_target, mispredict, redirect_pc,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, plus mispredict detection.
// Zero-latency lookup and mispredict; table/counter updates land on the next edge.
// No backpressure: one lookup and one resolve accepted every cycle.
module branch_predictor #(
  parameter int INDEX_BITS = 4,
  parameter int XLEN       = 32
) (
  input logic               clk,
  input logic               rst_n,
  branch_predictor_if.slave bp
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = XLEN - INDEX_BITS - 2;

  logic             valid_q [ENTRIES];
  logic             valid_d [ENTRIES];
  logic [TAG_W-1:0] tag_q   [ENTRIES];
  logic [TAG_W-1:0] tag_d   [ENTRIES];
  logic [XLEN-1:0]  tgt_q   [ENTRIES];
  logic [XLEN-1:0]  tgt_d   [ENTRIES];
  logic [1:0]       cnt_q   [ENTRIES];
  logic [1:0]       cnt_d   [ENTRIES];
  logic             unc_q   [ENTRIES];
  logic             unc_d   [ENTRIES];

  logic [31:0] br_cnt_q, br_cnt_d;
  logic [31:0] mis_cnt_q, mis_cnt_d;

  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]      if_tag, ex_tag;
  logic                  if_hit, ex_hit;
  logic                  mispredict;

  assign if_idx = bp.if_pc[INDEX_BITS+1:2];
  assign if_tag = bp.if_pc[XLEN-1:INDEX_BITS+2];
  assign ex_idx = bp.ex_pc[INDEX_BITS+1:2];
  assign ex_tag = bp.ex_pc[XLEN-1:INDEX_BITS+2];

  // Fetch lookup reads only registered state, so a same-cycle update is not visible yet.
  always_comb begin
    if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    bp.pred_taken  = if_hit && (unc_q[if_idx] || cnt_q[if_idx][1]);
    bp.pred_target = bp.pred_taken ? tgt_q[if_idx] : bp.if_pc + XLEN'(4);
  end

  // Compare the resolved outcome with what IF predicted for it.
  always_comb begin
    mispredict     = bp.ex_valid &&
                     ((bp.ex_taken != bp.ex_pred_taken) ||
                      (bp.ex_taken && (bp.ex_target != bp.ex_pred_target)));
    bp.mispredict  = mispredict;
    bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + XLEN'(4);
  end

  // Next table contents: flush wins over a resolve; a not-taken miss leaves the table alone.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      valid_d[i] = valid_q[i];
      tag_d[i]   = tag_q[i];
      tgt_d[i]   = tgt_q[i];
      cnt_d[i]   = cnt_q[i];
      unc_d[i]   = unc_q[i];
    end
    ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    if (bp.bp_flush) begin
      for (int i = 0; i < ENTRIES; i++) valid_d[i] = 1'b0;
    end else if (bp.ex_valid) begin
      if (ex_hit && bp.ex_taken) begin
        cnt_d[ex_idx] = (cnt_q[ex_idx] == 2'd3) ? 2'd3 : cnt_q[ex_idx] + 2'd1;
        tgt_d[ex_idx] = bp.ex_target;
        unc_d[ex_idx] = bp.ex_uncond;
      end else if (ex_hit) begin
        cnt_d[ex_idx] = (cnt_q[ex_idx] == 2'd0) ? 2'd0 : cnt_q[ex_idx] - 2'd1;
      end else if (bp.ex_taken) begin
        valid_d[ex_idx] = 1'b1;
        tag_d[ex_idx]   = ex_tag;
        tgt_d[ex_idx]   = bp.ex_target;
        cnt_d[ex_idx]   = 2'b10;
        unc_d[ex_idx]   = bp.ex_uncond;
      end
    end
  end

  // Saturating performance counters; a flush does not touch them.
  always_comb begin
    br_cnt_d  = (bp.ex_valid && (br_cnt_q != 32'hFFFF_FFFF)) ? br_cnt_q + 32'd1 : br_cnt_q;
    mis_cnt_d = (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) ? mis_cnt_q + 32'd1 : mis_cnt_q;
    bp.branch_count     = br_cnt_q;
    bp.mispredict_count = mis_cnt_q;
  end

  // State registers; reset leaves every entry invalid and weakly not-taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        cnt_q[i]   <= 2'b01;
        unc_q[i]   <= 1'b0;
      end
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= valid_d[i];
        tag_q[i]   <= tag_d[i];
        tgt_q[i]   <= tgt_d[i];
        cnt_q[i]   <= cnt_d[i];
        unc_q[i]   <= unc_d[i];
      end
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed scenarios with literal expectations plus
// a randomized phase, all compared every cycle against an abstract table model.
module tb_branch_predictor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_predictor_if #(.XLEN(32)) bif ();

  branch_predictor #(.INDEX_BITS(4), .XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bif)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b1;

  // Abstract model: 16 entries, counters kept as plain integers 0..3.
  bit          m_v   [16];
  logic [25:0] m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_cnt [16];
  bit          m_u   [16];
  logic [31:0] m_bc, m_mc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int i = int'(pc[5:2]);
    return m_v[i] && (m_tag[i] == pc[31:6]);
  endfunction

  function automatic bit m_pt(input logic [31:0] pc);
    int i = int'(pc[5:2]);
    return m_hit(pc) && (m_u[i] || m_cnt[i] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pt(pc) ? m_tgt[int'(pc[5:2])] : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    if (!bif.ex_valid) return 1'b0;
    if (bif.ex_taken != bif.ex_pred_taken) return 1'b1;
    return bif.ex_taken && (bif.ex_target != bif.ex_pred_target);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 1'b0; m_cnt[i] = 1; m_u[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  task automatic model_update();
    int i = int'(bif.ex_pc[5:2]);
    bit hit = m_hit(bif.ex_pc);
    if (bif.ex_valid && m_bc != 32'hFFFF_FFFF) m_bc = m_bc + 1;
    if (m_mis() && m_mc != 32'hFFFF_FFFF) m_mc = m_mc + 1;
    if (bif.bp_flush) begin
      for (int k = 0; k < 16; k++) m_v[k] = 1'b0;
    end else if (bif.ex_valid) begin
      if (hit && bif.ex_taken) begin
        m_cnt[i] = (m_cnt[i] < 3) ? m_cnt[i] + 1 : 3;
        m_tgt[i] = bif.ex_target;
        m_u[i]   = bif.ex_uncond;
      end else if (hit) begin
        m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
      end else if (bif.ex_taken) begin
        m_v[i] = 1'b1; m_tag[i] = bif.ex_pc[31:6]; m_tgt[i] = bif.ex_target;
        m_cnt[i] = 2; m_u[i] = bif.ex_uncond;
      end
    end
  endtask

  // Per-cycle compare, 3 time units after the input-change edge, then advance the model.
  always begin
    @(negedge clk);
    #3;
    if (chk_en) begin
      if (!rst_n) model_reset();
      chk("pred_taken", 32'(bif.pred_taken), 32'(m_pt(bif.if_pc)));
      chk("pred_target", bif.pred_target, m_ptgt(bif.if_pc));
      chk("mispredict", 32'(bif.mispredict), 32'(m_mis()));
      chk("redirect_pc", bif.redirect_pc, bif.ex_taken ? bif.ex_target : bif.ex_pc + 32'd4);
      chk("branch_count", bif.branch_count, m_bc);
      chk("mispredict_count", bif.mispredict_count, m_mc);
      if (rst_n) model_update();
    end
  end

  task automatic set_ex(input bit v, input logic [31:0] pc, input bit tk, input bit unc,
                        input logic [31:0] tgt, input bit pt, input logic [31:0] ptg);
    bif.ex_valid = v; bif.ex_pc = pc; bif.ex_taken = tk; bif.ex_uncond = unc;
    bif.ex_target = tgt; bif.ex_pred_taken = pt; bif.ex_pred_target = ptg;
  endtask

  task automatic cyc(input logic [31:0] ipc, input bit v, input logic [31:0] pc, input bit tk,
                     input bit unc, input logic [31:0] tgt, input bit fl);
    @(negedge clk);
    bif.if_pc = ipc;
    bif.bp_flush = fl;
    set_ex(v, pc, tk, unc, tgt, m_pt(pc), m_ptgt(pc));
    #2;
  endtask

  initial begin
    bif.if_pc = 32'hFFFF_FFFC;
    bif.bp_flush = 1'b0;
    set_ex(1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk); #2;
    chk("lit_wrap_pred_target", bif.pred_target, 32'h0);
    chk("lit_wrap_redirect", bif.redirect_pc, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bif.if_pc = 32'h100;
    #2;
    chk("lit_reset_pred_taken", 32'(bif.pred_taken), 32'd0);
    chk("lit_reset_pred_target", bif.pred_target, 32'h104);
    chk("lit_reset_bcount", bif.branch_count, 32'd0);

    // first resolve allocates with a mispredict
    @(negedge clk);
    set_ex(1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0, 32'h104);
    #2;
    chk("lit_first_mispredict", 32'(bif.mispredict), 32'd1);
    chk("lit_first_redirect", bif.redirect_pc, 32'h80);
    cyc(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_alloc_pred_taken", 32'(bif.pred_taken), 32'd1);
    chk("lit_alloc_pred_target", bif.pred_target, 32'h80);
    chk("lit_alloc_bcount", bif.branch_count, 32'd1);
    chk("lit_alloc_mcount", bif.mispredict_count, 32'd1);

    // hysteresis: 2 -> 1 -> 3 -> 2 -> (x4 taken) 3 -> 2 -> 1
    cyc(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
    cyc(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_hyst_cnt1", 32'(bif.pred_taken), 32'd0);
    repeat (2) cyc(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
    cyc(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
    cyc(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_hyst_cnt2", 32'(bif.pred_taken), 32'd1);
    repeat (4) cyc(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h80, 1'b0);
    repeat (2) cyc(32'h100, 1'b1, 32'h100, 1'b0, 1'b0, 32'h80, 1'b0);
    cyc(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_hyst_sat", 32'(bif.pred_taken), 32'd0);

    // aliasing at index 0
    cyc(32'h100, 1'b1, 32'h140, 1'b1, 1'b0, 32'h900, 1'b0);
    cyc(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_alias_miss", bif.pred_target, 32'h104);
    bif.if_pc = 32'h140;
    #1;
    chk("lit_alias_hit", bif.pred_target, 32'h900);
    cyc(32'h200, 1'b1, 32'h200, 1'b1, 1'b1, 32'h40, 1'b0);
    repeat (2) cyc(32'h200, 1'b1, 32'h200, 1'b0, 1'b1, 32'h40, 1'b0);
    cyc(32'h200, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_jal_uncond", 32'(bif.pred_taken), 32'd1);
    chk("lit_jal_target", bif.pred_target, 32'h40);

    // same-cycle read/write and flush priority
    cyc(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 32'h300, 1'b0);
    chk("lit_same_old", bif.pred_target, 32'h104);
    cyc(32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_same_new", bif.pred_target, 32'h300);
    cyc(32'h100, 1'b1, 32'h140, 1'b1, 1'b0, 32'h700, 1'b1);
    cyc(32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_flush_drop", bif.pred_target, 32'h144);

    // randomized phase over a small PC pool so entries hit and alias
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] ipc, epc, etg;
      ipc = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
      epc = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
      if ($urandom_range(0, 31) == 0) ipc = 32'hFFFF_FFFC;
      if ($urandom_range(0, 31) == 0) epc = 32'hFFFF_FFFC;
      etg = {20'h0, 10'($urandom), 2'b00};
      @(negedge clk);
      bif.if_pc = ipc;
      bif.bp_flush = ($urandom_range(0, 63) == 0);
      set_ex($urandom_range(0, 3) != 0, epc, 1'($urandom), 1'($urandom_range(0, 5) == 0),
             etg, m_pt(epc), m_ptgt(epc));
      if ($urandom_range(0, 7) == 0) bif.ex_pred_taken = ~bif.ex_pred_taken;
      if ($urandom_range(0, 7) == 0) bif.ex_pred_target = etg;
    end

    // saturation of both counters, then asynchronous mid-cycle reset
    cyc(32'h3C0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    cyc(32'h3C0, 1'b1, 32'h3C0, 1'b1, 1'b0, 32'h500, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    set_ex(1'b1, 32'h3C0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h500);
    force dut.mis_cnt_q = 32'hFFFF_FFFF;
    force dut.br_cnt_q = 32'hFFFF_FFFF;
    #2;
    chk("lit_pre_reset_pred", 32'(bif.pred_taken), 32'd1);
    chk("lit_sat_mispredict", 32'(bif.mispredict), 32'd1);
    chk("lit_sat_mcount_next", dut.mis_cnt_d, 32'hFFFF_FFFF);
    chk("lit_sat_bcount_next", dut.br_cnt_d, 32'hFFFF_FFFF);
    set_ex(1'b0, 32'h3C0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    release dut.mis_cnt_q;
    release dut.br_cnt_q;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("lit_arst_pred_taken", 32'(bif.pred_taken), 32'd0);
    chk("lit_arst_pred_target", bif.pred_target, 32'h3C4);
    chk("lit_arst_mcount", bif.mispredict_count, 32'd0);
    chk("lit_arst_bcount", bif.branch_count, 32'd0);
    chk_en = 1'b1;
    @(negedge clk);
    #4;
    rst_n = 1'b1;
    repeat (3) cyc(32'h3C0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("lit_post_reset_pred", 32'(bif.pred_taken), 32'd0);
    @(negedge clk);
    #4;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
